// File: rtl/rgbw_pkg.sv
// Shared mode codes and state encodings for the hue-to-RGBW generator.
package rgbw_pkg;

   localparam logic [7:0] MODE_DIRECT = 8'h21;
   localparam logic [7:0] MODE_HUE    = 8'hA4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SWEEP = 3'd1;
   localparam logic [2:0] ST_WADD  = 3'd2;
   localparam logic [2:0] ST_SCALE = 3'd3;
   localparam logic [2:0] ST_APPLY = 3'd4;

endpackage

// File: rtl/rgbw_scaler.sv
// One-channel serial scaler: result = (ch * mult) >> DW, one multiplier bit per cycle.
module rgbw_scaler #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] ch,
   input  logic [DW:0]   mult,
   output logic [DW-1:0] result,
   output logic          done
);

   localparam int CNT_W = $clog2(DW + 1);

   logic             running;
   logic [CNT_W-1:0] cnt;
   logic [DW-1:0]    ch_q;
   logic [DW:0]      mplier;
   logic [DW:0]      acc;
   logic [DW:0]      sum;

   // Right-shifting accumulator keeps only the high half; the last bit is added without a shift
   // so the total shift is DW rather than DW+1.
   assign sum    = acc + (mplier[0] ? {1'b0, ch_q} : '0);
   assign done   = running && (cnt == CNT_W'(DW));
   assign result = acc[DW] ? '1 : acc[DW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         running <= 1'b0;
         cnt     <= '0;
         ch_q    <= '0;
         mplier  <= '0;
         acc     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         ch_q    <= ch;
         mplier  <= mult;
         acc     <= '0;
      end else if (running) begin
         acc    <= (cnt == CNT_W'(DW)) ? sum : (sum >> 1);
         mplier <= mplier >> 1;
         cnt    <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(DW)) running <= 1'b0;
      end
   end

endmodule

// File: rtl/hue_rgbw_gen.sv
// Hue sweep plus white add and intensity scaling into registered RGBW outputs; direct pass-through otherwise.
module hue_rgbw_gen
   import rgbw_pkg::*;
#(
   parameter int DW      = 8,
   parameter int HUE_W   = 8,
   parameter int SEG_LEN = 36,
   parameter int STEP    = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       mode,
   input  logic             start,
   input  logic [HUE_W-1:0] hue,
   input  logic [DW-1:0]    lint,
   input  logic [DW-1:0]    white_in,
   input  logic [DW-1:0]    red_in,
   input  logic [DW-1:0]    green_in,
   input  logic [DW-1:0]    blue_in,
   output logic [DW-1:0]    red_out,
   output logic [DW-1:0]    green_out,
   output logic [DW-1:0]    blue_out,
   output logic [DW-1:0]    white_out,
   output logic             busy,
   output logic             done
);

   localparam logic [DW-1:0] MAX  = '1;
   localparam int            CW   = 16;
   localparam int            SPAN = 6 * SEG_LEN;

   logic [2:0]       state;
   logic [CW-1:0]    counter;
   logic [CW-1:0]    limit;
   logic [HUE_W-1:0] hue_q;
   logic [DW-1:0]    lint_q;
   logic [DW-1:0]    white_q;
   logic [DW-1:0]    r, g, b;
   logic [2:0]       seg;
   logic [DW-1:0]    sum_r, sum_g, sum_b;
   logic [DW:0]      mult;
   logic             scale_start;
   logic [DW-1:0]    res_r, res_g, res_b, res_w;
   logic             done_r, done_g, done_b, done_w;

   function automatic logic [DW-1:0] sat_up(input logic [DW-1:0] v);
      logic [DW:0] s;
      s = {1'b0, v} + (DW+1)'(STEP);
      return s[DW] ? MAX : s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] sat_dn(input logic [DW-1:0] v);
      logic [DW:0] s;
      s = {1'b0, v} - (DW+1)'(STEP);
      return s[DW] ? '0 : s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] c);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, c};
      return s[DW] ? MAX : s[DW-1:0];
   endfunction

   assign limit       = (CW'(hue_q) < CW'(SPAN)) ? CW'(hue_q) : CW'(SPAN);
   assign seg         = 3'(counter / CW'(SEG_LEN));
   assign sum_r       = sat_add(r, white_q);
   assign sum_g       = sat_add(g, white_q);
   assign sum_b       = sat_add(b, white_q);
   assign mult        = {1'b0, lint_q} + (DW+1)'(1);
   assign scale_start = (state == ST_WADD);

   // Scalers load the white-added sums during WADD and iterate through SCALE.
   rgbw_scaler #(.DW(DW)) u_scale_r (.clk(clk), .reset(reset), .start(scale_start), .ch(sum_r),   .mult(mult), .result(res_r), .done(done_r));
   rgbw_scaler #(.DW(DW)) u_scale_g (.clk(clk), .reset(reset), .start(scale_start), .ch(sum_g),   .mult(mult), .result(res_g), .done(done_g));
   rgbw_scaler #(.DW(DW)) u_scale_b (.clk(clk), .reset(reset), .start(scale_start), .ch(sum_b),   .mult(mult), .result(res_b), .done(done_b));
   rgbw_scaler #(.DW(DW)) u_scale_w (.clk(clk), .reset(reset), .start(scale_start), .ch(white_q), .mult(mult), .result(res_w), .done(done_w));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         counter   <= '0;
         hue_q     <= '0;
         lint_q    <= '0;
         white_q   <= '0;
         r         <= '0;
         g         <= '0;
         b         <= '0;
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
         white_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mode == MODE_DIRECT) begin
                  red_out   <= red_in;
                  green_out <= green_in;
                  blue_out  <= blue_in;
                  white_out <= white_in;
               end else if (mode == MODE_HUE && start) begin
                  hue_q   <= hue;
                  lint_q  <= lint;
                  white_q <= white_in;
                  r       <= MAX;
                  g       <= '0;
                  b       <= '0;
                  counter <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               if (counter < limit) begin
                  case (seg)
                     3'd0:    begin b <= sat_up(b); r <= MAX; g <= '0;  end
                     3'd1:    begin r <= sat_dn(r); g <= '0;  b <= MAX; end
                     3'd2:    begin g <= sat_up(g); r <= '0;  b <= MAX; end
                     3'd3:    begin b <= sat_dn(b); r <= '0;  g <= MAX; end
                     3'd4:    begin r <= sat_up(r); g <= MAX; b <= '0;  end
                     default: begin g <= sat_dn(g); r <= MAX; b <= '0;  end
                  endcase
                  counter <= counter + CW'(1);
               end else begin
                  // A hue past the full wheel lands back on pure red.
                  if (CW'(hue_q) >= CW'(SPAN)) begin
                     r <= MAX;
                     g <= '0;
                     b <= '0;
                  end
                  state <= ST_WADD;
               end
            end
            ST_WADD: begin
               r     <= sum_r;
               g     <= sum_g;
               b     <= sum_b;
               state <= ST_SCALE;
            end
            ST_SCALE: begin
               if (done_r & done_g & done_b & done_w) state <= ST_APPLY;
            end
            ST_APPLY: begin
               red_out   <= res_r;
               green_out <= res_g;
               blue_out  <= res_b;
               white_out <= res_w;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hue_rgbw_gen.sv
// Directed-vector bench for hue_rgbw_gen with DW=8, STEP=7, SEG_LEN=36.
module tb_hue_rgbw_gen;

   logic       clk;
   logic       reset;
   logic [7:0] mode;
   logic       start;
   logic [7:0] hue, lint, white_in, red_in, green_in, blue_in;
   logic [7:0] red_out, green_out, blue_out, white_out;
   logic       busy, done;

   int vectors;
   int miscompares;

   hue_rgbw_gen #(.DW(8), .HUE_W(8), .SEG_LEN(36), .STEP(7)) dut (
      .clk(clk), .reset(reset), .mode(mode), .start(start), .hue(hue), .lint(lint),
      .white_in(white_in), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .white_out(white_out),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic launch(input logic [7:0] h, input logic [7:0] l, input logic [7:0] w);
      @(posedge clk);
      #1;
      hue = h; lint = l; white_in = w; mode = 8'hA4; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int lat);
      bit found;
      found = 0;
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         if (!found) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
               lat = k;
               found = 1;
            end
         end
      end
   endtask

   task automatic test_reset;
      vectors++;
      if ({red_out, green_out, blue_out, white_out, busy, done} !== 34'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %h/%h/%h/%h busy=%b done=%b, want all zero",
                  red_out, green_out, blue_out, white_out, busy, done);
      end
   endtask

   task automatic test_direct;
      bit saw_done;
      @(posedge clk);
      #1;
      mode = 8'h21; red_in = 8'h12; green_in = 8'h34; blue_in = 8'h56; white_in = 8'h78;
      saw_done = 0;
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1;
      vectors++;
      if ({red_out, green_out, blue_out, white_out} !== 32'h12345678 || saw_done) begin
         miscompares++;
         $display("[TB] FAIL direct_pass: got %h%h%h%h done=%b, want 12345678 done=0",
                  red_out, green_out, blue_out, white_out, saw_done);
      end
      mode = 8'h00; red_in = 8'hAA; start = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      start = 1'b0;
      vectors++;
      if (red_out !== 8'h12 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL other_mode_hold: got red=%h busy=%b, want red=12 busy=0", red_out, busy);
      end
   endtask

   task automatic test_hue_zero;
      int lat;
      launch(8'd0, 8'hFF, 8'h00);
      wait_done(400, lat);
      vectors++;
      if (lat != 12) begin
         miscompares++;
         $display("[TB] FAIL hue0_latency: got %0d, want 12", lat);
      end
      vectors++;
      if ({red_out, green_out, blue_out, white_out} !== 32'hFF000000) begin
         miscompares++;
         $display("[TB] FAIL hue0_colour: got %h%h%h%h, want FF000000", red_out, green_out, blue_out, white_out);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL done_pulse_width: got done=%b busy=%b, want 0/0", done, busy);
      end
   endtask

   task automatic test_hue_white;
      int lat;
      launch(8'd40, 8'hFF, 8'h40);
      wait_done(400, lat);
      vectors++;
      if (lat != 52) begin
         miscompares++;
         $display("[TB] FAIL hue40_latency: got %0d, want 52", lat);
      end
      vectors++;
      if ({red_out, green_out, blue_out, white_out} !== 32'hFF40FF40) begin
         miscompares++;
         $display("[TB] FAIL hue40_colour: got %h%h%h%h, want FF40FF40", red_out, green_out, blue_out, white_out);
      end
   endtask

   task automatic test_scale_half;
      int lat;
      launch(8'd0, 8'h7F, 8'h00);
      wait_done(400, lat);
      // 255 * 128 >> 8 = 127
      vectors++;
      if (red_out !== 8'h7F || lat != 12) begin
         miscompares++;
         $display("[TB] FAIL scale_half: got red=%h lat=%0d, want red=7F lat=12", red_out, lat);
      end
      launch(8'd0, 8'h00, 8'h90);
      wait_done(400, lat);
      vectors++;
      if ({red_out, green_out, blue_out, white_out} !== 32'h00000000) begin
         miscompares++;
         $display("[TB] FAIL scale_zero: got %h%h%h%h, want 00000000", red_out, green_out, blue_out, white_out);
      end
   endtask

   task automatic test_wrap;
      int lat;
      launch(8'd100, 8'hFF, 8'h00);
      wait_done(400, lat);
      // 72 steps: seg0 b=252, seg1 r=255-252=3, seg2 r forced 0, g +7*28=196
      vectors++;
      if ({red_out, green_out, blue_out} !== 24'h00C4FF || lat != 112) begin
         miscompares++;
         $display("[TB] FAIL hue100: got %h%h%h lat=%0d, want 00C4FF lat=112", red_out, green_out, blue_out, lat);
      end
      launch(8'hF0, 8'hFF, 8'h00);
      wait_done(400, lat);
      vectors++;
      if ({red_out, green_out, blue_out} !== 24'hFF0000 || lat != 228) begin
         miscompares++;
         $display("[TB] FAIL hue_overrange: got %h%h%h lat=%0d, want FF0000 lat=228", red_out, green_out, blue_out, lat);
      end
   endtask

   task automatic test_back_to_back;
      int dones, lat;
      logic [31:0] at_done;
      dones = 0; lat = -1; at_done = '0;
      red_in = 8'h11; green_in = 8'h22; blue_in = 8'h33;
      launch(8'd10, 8'hFF, 8'h00);
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            dones++;
            if (lat < 0) begin
               lat = k;
               at_done = {red_out, green_out, blue_out, white_out};
            end
         end
         start = (k == 3 || k == 8 || k == 15);
         hue = 8'd200;
         if (k == 6) begin
            mode = 8'h21;
            white_in = 8'h44;
         end
      end
      start = 1'b0;
      vectors++;
      if (dones != 1 || lat != 22) begin
         miscompares++;
         $display("[TB] FAIL busy_restart: got %0d dones lat=%0d, want 1 done lat=22", dones, lat);
      end
      vectors++;
      if (at_done !== 32'hFF004600) begin
         miscompares++;
         $display("[TB] FAIL hue10_colour: got %h, want FF004600", at_done);
      end
      vectors++;
      if ({red_out, green_out, blue_out, white_out} !== 32'h11223344) begin
         miscompares++;
         $display("[TB] FAIL mode_after_run: got %h%h%h%h, want 11223344", red_out, green_out, blue_out, white_out);
      end
   endtask

   task automatic test_reset_abort;
      int dones, lat;
      dones = 0;
      launch(8'd40, 8'hFF, 8'h40);
      for (int k = 1; k <= 5; k++) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      vectors++;
      if ({red_out, green_out, blue_out, white_out, busy, done} !== 34'h0) begin
         miscompares++;
         $display("[TB] FAIL abort_clear: got %h%h%h%h busy=%b, want zeros", red_out, green_out, blue_out, white_out, busy);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dones++;
      end
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_done: got %0d dones, want 0", dones);
      end
      launch(8'd0, 8'hFF, 8'h00);
      wait_done(400, lat);
      vectors++;
      if (lat != 12 || {red_out, green_out, blue_out, white_out} !== 32'hFF000000) begin
         miscompares++;
         $display("[TB] FAIL restart_after_reset: got %h%h%h%h lat=%0d, want FF000000 lat=12",
                  red_out, green_out, blue_out, white_out, lat);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b0; mode = 8'h00; start = 1'b0; hue = '0; lint = '0;
      white_in = '0; red_in = '0; green_in = '0; blue_in = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b1;
      test_direct();
      test_hue_zero();
      test_hue_white();
      test_scale_half();
      test_wrap();
      test_back_to_back();
      mode = 8'hA4;
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
